// File: rtl/fifo_sync_ram_pkg.sv
// Shared definitions for the synchronous RAM-based FIFO.
//   FIFO_STD / FIFO_FWFT : values of the FWFT mode parameter
//   get_depth()          : number of words addressed by an address width
//   clog2()              : ceiling log2, for callers sizing counters
package fifo_sync_ram_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int get_depth(input int addrwidth);
        return 1 << addrwidth;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_sync_ram_ram_sdp.sv
// Simple-dual-port RAM with one write port and one registered read port.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, clears only the read register
//   we_i     : write enable, stores di_i at waddr_i
//   waddr_i  : write address
//   di_i     : write data
//   re_i     : read enable, loads do_o from raddr_i on the next edge
//   raddr_i  : read address
//   do_o     : registered read data, holds its value while re_i is low
module fifo_sync_ram_ram_sdp
    import fifo_sync_ram_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [ADDRWIDTH-1:0] waddr_i,
    input  logic [DATAWIDTH-1:0] di_i,
    input  logic                 re_i,
    input  logic [ADDRWIDTH-1:0] raddr_i,
    output logic [DATAWIDTH-1:0] do_o
);

    localparam int DEPTH = get_depth(ADDRWIDTH);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] do_q;

    // Array kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= di_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            do_q <= '0;
        end else if (re_i) begin
            do_q <= mem_q[raddr_i];
        end
    end

    assign do_o = do_q;

endmodule

// File: rtl/fifo_sync_ram.sv
// Synchronous single-clock FIFO on a simple-dual-port RAM, depth 2**ADDRWIDTH.
// Standard mode returns data one cycle after an accepted read; FWFT mode
// presents the head word on do_o with valid_o and rd_en_i acknowledges it.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wr_en_i, di_i         : write request and data
//   rd_en_i               : read request (std) / acknowledge (FWFT)
//   do_o, valid_o         : registered read data and its qualifier
//   full_o, empty_o       : count == DEPTH / count == 0
//   almost_full_o         : count >= AFULL_THRESH
//   almost_empty_o        : count <= AEMPTY_THRESH
//   count_o               : words held, including the FWFT output stage
//   overflow_o            : pulse, write dropped because full
//   underflow_o           : pulse, read request refused
module fifo_sync_ram
    import fifo_sync_ram_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int ADDRWIDTH     = 4,
    parameter int FWFT          = FIFO_STD,
    parameter int AFULL_THRESH  = get_depth(ADDRWIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [DATAWIDTH-1:0] di_i,
    input  logic                 rd_en_i,
    output logic [DATAWIDTH-1:0] do_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [ADDRWIDTH:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int               DEPTH    = get_depth(ADDRWIDTH);
    localparam logic [ADDRWIDTH:0] DEPTH_C  = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] AFULL_C  = (ADDRWIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDRWIDTH:0] AEMPTY_C = (ADDRWIDTH+1)'(AEMPTY_THRESH);
    localparam bit               IS_FWFT  = (FWFT == FIFO_FWFT);

    logic [ADDRWIDTH-1:0] wptr_q;
    logic [ADDRWIDTH-1:0] rptr_q;
    logic [ADDRWIDTH:0]   count_q;
    logic [ADDRWIDTH:0]   count_d;
    logic [ADDRWIDTH:0]   ram_cnt;
    logic                 valid_q;
    logic                 valid_d;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 rd_refused;
    logic                 ram_re;

    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);

    always_comb begin
        wr_acc     = wr_en_i && !full_o;
        ram_cnt    = count_q;
        rd_acc     = 1'b0;
        rd_refused = 1'b0;
        ram_re     = 1'b0;
        valid_d    = 1'b0;
        if (IS_FWFT) begin
            // The RAM's read register doubles as the output stage, so the
            // words still in the array are count minus the one being shown.
            ram_cnt    = count_q - (ADDRWIDTH+1)'(valid_q);
            rd_acc     = rd_en_i && valid_q;
            rd_refused = rd_en_i && !valid_q;
            ram_re     = (ram_cnt != '0) && (!valid_q || rd_en_i);
            valid_d    = ram_re || (valid_q && !rd_en_i);
        end else begin
            rd_acc     = rd_en_i && !empty_o;
            rd_refused = rd_en_i && empty_o;
            ram_re     = rd_acc;
            valid_d    = rd_acc;
        end

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (ram_re) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= wr_en_i && full_o;
            unf_q   <= rd_refused;
        end
    end

    fifo_sync_ram_ram_sdp #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_acc && !rst_i),
        .waddr_i (wptr_q),
        .di_i    (di_i),
        .re_i    (ram_re && !rst_i),
        .raddr_i (rptr_q),
        .do_o    (do_o)
    );

    assign valid_o     = valid_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_fifo_sync_ram.sv
module tb_fifo_sync_ram;
    import fifo_sync_ram_pkg::*;

    localparam int DEPTH = get_depth(4);

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] di;

    logic [7:0] s_do, f_do;
    logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_ram #(.DATAWIDTH(8), .ADDRWIDTH(4), .FWFT(FIFO_STD)) u_std (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr), .di_i(di), .rd_en_i(rd),
        .do_o(s_do), .valid_o(s_valid), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    fifo_sync_ram #(.DATAWIDTH(8), .ADDRWIDTH(4), .FWFT(FIFO_FWFT)) u_fwft (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr), .di_i(di), .rd_en_i(rd),
        .do_o(f_do), .valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    // Reference models: std is a plain queue; FWFT is a queue of stored
    // words plus one presentation slot that refills from the queue.
    logic [7:0] sq[$];
    logic [7:0] sdo;
    logic       svalid, sovf, sunf;
    logic [7:0] fq[$];
    logic [7:0] fdo;
    logic       fvalid, fovf, funf;

    typedef struct {
        logic       r;
        logic       w;
        logic       rd;
        logic [7:0] d;
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       valid;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [7:0] d, input logic rdq);
        logic s_wr_ok;
        logic f_wr_ok;
        int   ftot;
        if (r) begin
            sq.delete();
            sdo = 8'h00; svalid = 1'b0; sovf = 1'b0; sunf = 1'b0;
            fq.delete();
            fdo = 8'h00; fvalid = 1'b0; fovf = 1'b0; funf = 1'b0;
        end else begin
            s_wr_ok = w && (sq.size() < DEPTH);
            sovf    = w && (sq.size() == DEPTH);
            sunf    = rdq && (sq.size() == 0);
            svalid  = 1'b0;
            if (rdq && sq.size() > 0) begin
                sdo    = sq.pop_front();
                svalid = 1'b1;
            end
            if (s_wr_ok) sq.push_back(d);

            ftot    = fq.size() + int'(fvalid);
            f_wr_ok = w && (ftot < DEPTH);
            fovf    = w && (ftot == DEPTH);
            funf    = rdq && !fvalid;
            if (rdq && fvalid) fvalid = 1'b0;
            if (!fvalid && fq.size() > 0) begin
                fdo    = fq.pop_front();
                fvalid = 1'b1;
            end
            if (f_wr_ok) fq.push_back(d);
        end
    endtask

    task automatic compare_all();
        int st;
        int ft;
        st = sq.size();
        ft = fq.size() + int'(fvalid);
        check("s_count", 32'(s_count), st);
        check("s_empty", 32'(s_empty), 32'(st == 0));
        check("s_full", 32'(s_full), 32'(st == DEPTH));
        check("s_afull", 32'(s_af), 32'(st >= DEPTH - 2));
        check("s_aempty", 32'(s_ae), 32'(st <= 2));
        check("s_valid", 32'(s_valid), 32'(svalid));
        check("s_do", 32'(s_do), 32'(sdo));
        check("s_ovf", 32'(s_ovf), 32'(sovf));
        check("s_unf", 32'(s_unf), 32'(sunf));
        check("f_count", 32'(f_count), ft);
        check("f_empty", 32'(f_empty), 32'(ft == 0));
        check("f_full", 32'(f_full), 32'(ft == DEPTH));
        check("f_afull", 32'(f_af), 32'(ft >= DEPTH - 2));
        check("f_aempty", 32'(f_ae), 32'(ft <= 2));
        check("f_valid", 32'(f_valid), 32'(fvalid));
        check("f_do", 32'(f_do), 32'(fdo));
        check("f_ovf", 32'(f_ovf), 32'(fovf));
        check("f_unf", 32'(f_unf), 32'(funf));
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rdq);
        rst = r;
        wr  = w;
        di  = d;
        rd  = rdq;
        @(posedge clk);
        #1;
        model_edge(r, w, d, rdq);
        compare_all();
    endtask

    initial begin
        logic [7:0] w5[4];
        int         phase;
        int         pwr;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; di = 8'h00;

        //            r     w     rd    d      cnt   emp   full  vld   do     ovf   unf
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 8'h55, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rd);
            check("tbl_count", 32'(s_count), 32'(tbl[i].count));
            check("tbl_empty", 32'(s_empty), 32'(tbl[i].empty));
            check("tbl_full", 32'(s_full), 32'(tbl[i].full));
            check("tbl_valid", 32'(s_valid), 32'(tbl[i].valid));
            check("tbl_do", 32'(s_do), 32'(tbl[i].dout));
            check("tbl_ovf", 32'(s_ovf), 32'(tbl[i].ovf));
            check("tbl_unf", 32'(s_unf), 32'(tbl[i].unf));
        end

        // Fill to full, almost_full from 14, then one dropped write.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            check("fill_count", 32'(s_count), i);
            check("fill_afull", 32'(s_af), 32'(i >= 14));
        end
        check("fill_full", 32'(s_full), 1);
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        check("fill_ovf", 32'(s_ovf), 1);
        check("fill_cnt16", 32'(s_count), 16);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_pulse", 32'(s_ovf), 0);

        // Drain in order, then one refused read.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            check("drain_valid", 32'(s_valid), 1);
            check("drain_do", 32'(s_do), i);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("drain_unf", 32'(s_unf), 1);
        check("drain_valid0", 32'(s_valid), 0);
        check("drain_empty", 32'(s_empty), 1);

        // Streaming at constant occupancy 3 across the pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b1, 8'(8'h43 + k), 1'b1);
            check("wrap_count", 32'(s_count), 3);
            check("wrap_do", 32'(s_do), 32'(8'h40 + k));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read and write at count 5, at empty, at full.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'h65, 1'b1);
        check("rw5_count", 32'(s_count), 5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("rw_empty", 32'(s_empty), 1);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        check("rwe_unf", 32'(s_unf), 1);
        check("rwe_count", 32'(s_count), 1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        check("rwf_full", 32'(s_full), 1);
        step(1'b0, 1'b1, 8'h99, 1'b1);
        check("rwf_count", 32'(s_count), 15);
        check("rwf_ovf", 32'(s_ovf), 1);
        check("rwf_valid", 32'(s_valid), 1);
        check("rwf_do", 32'(s_do), 32'(8'h77));

        // FWFT: first word appears two edges after the write, then a held
        // rd_en streams one word per cycle.
        w5[0] = 8'hA5; w5[1] = 8'hB0; w5[2] = 8'hB1; w5[3] = 8'hB2;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, w5[0], 1'b0);
        check("fw_valid_early", 32'(f_valid), 0);
        check("fw_not_empty", 32'(f_empty), 0);
        step(1'b0, 1'b1, w5[1], 1'b0);
        check("fw_valid", 32'(f_valid), 1);
        check("fw_do", 32'(f_do), 32'(w5[0]));
        step(1'b0, 1'b1, w5[2], 1'b0);
        step(1'b0, 1'b1, w5[3], 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("fw_head", 32'(f_do), 32'(w5[0]));
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            if (k < 4) begin
                check("fw_stream_valid", 32'(f_valid), 1);
                check("fw_stream_do", 32'(f_do), 32'(w5[k]));
            end else begin
                check("fw_stream_end", 32'(f_valid), 0);
                check("fw_stream_empty", 32'(f_empty), 1);
            end
        end

        // Reset mid-operation discards contents and clears the outputs.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("pre_rst_count", 32'(s_count), 9);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_valid", 32'(s_valid), 0);
        check("rst_do", 32'(s_do), 0);
        check("rst_f_do", 32'(f_do), 0);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst_do", 32'(s_do), 32'(8'h3C));
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("post_rst_f_do", 32'(f_do), 32'(8'h3C));

        // Random traffic against the models, with shifting write pressure.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            phase = (n / 250) % 3;
            pwr   = (phase == 0) ? 70 : ((phase == 1) ? 50 : 30);
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 99) < pwr),
                 8'($urandom),
                 ($urandom_range(0, 99) < 50));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
